// File: rtl/io_out_port_fifo_pkg.sv
// Shared constants and control bundle for the OUT-port FIFO.
// Word width, storage depth and pointer width match the core Out bus.
package io_out_port_fifo_pkg;

  localparam int IO_DATA_W     = 16;
  localparam int IO_FIFO_DEPTH = 4;
  localparam int IO_FIFO_AW    = 2;

  // Per-edge decisions, mutually exclusive where used in a decoder:
  // rd/byp/idle select what the output register does this edge.
  typedef struct packed {
    logic rd;
    logic byp;
    logic idle;
    logic wr;
    logic drop;
  } fifo_ctl_t;

endpackage

// File: rtl/io_fifo_ram.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read.
// Ports: Clk, we_i/waddr_i/wdata_i write side, raddr_i/rdata_o read side.
module io_fifo_ram
  import io_out_port_fifo_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_FIFO_DEPTH,
  parameter int ADDR_W = IO_FIFO_AW
) (
  input  logic              Clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/io_out_port_fifo.sv
// Buffers core OUT words and drains them to a device over valid/ready.
// Ports: Clk, Rst (async, low), OutData/OutWe/Full/Overflow/OvfClr core
// side, DevData/DevValid/DevReady device side, Count words held.
module io_out_port_fifo
  import io_out_port_fifo_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_FIFO_DEPTH,
  parameter int ADDR_W = IO_FIFO_AW
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] OutData,
  input  logic              OutWe,
  output logic              Full,
  output logic              Overflow,
  input  logic              OvfClr,
  output logic [DATA_W-1:0] DevData,
  output logic              DevValid,
  input  logic              DevReady,
  output logic [ADDR_W:0]   Count
);

  localparam logic [ADDR_W:0] CntFull = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] rdata;
  logic              empty;
  logic              full;
  logic              free;
  fifo_ctl_t         ctl;

  io_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .Clk     (Clk),
    .we_i    (ctl.wr),
    .waddr_i (wptr_q),
    .wdata_i (OutData),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntFull);

  // Output register can take a new word if empty or being accepted now.
  assign free = !vld_q | DevReady;

  always_comb begin
    ctl      = '0;
    ctl.rd   = !empty & free;
    ctl.byp  = empty & free & OutWe;
    ctl.idle = free & !ctl.rd & !ctl.byp;
    // A write while full is dropped even if a drain frees a slot.
    ctl.wr   = OutWe & !full & !ctl.byp;
    ctl.drop = OutWe & full;
  end

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    unique case (1'b1)
      ctl.rd: begin
        vld_d  = 1'b1;
        dat_d  = rdata;
        rptr_d = rptr_q + 1'b1;
      end
      ctl.byp: begin
        vld_d = 1'b1;
        dat_d = OutData;
      end
      ctl.idle: begin
        vld_d = 1'b0;
      end
      default: begin
      end
    endcase

    if (ctl.wr) begin
      wptr_d = wptr_q + 1'b1;
    end

    unique case ({ctl.wr, ctl.rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // Set beats clear on the same edge.
    if (ctl.drop) begin
      ovf_d = 1'b1;
    end else if (OvfClr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      dat_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Full     = full;
  assign Overflow = ovf_q;
  assign DevData  = dat_q;
  assign DevValid = vld_q;
  assign Count    = cnt_q + {{ADDR_W{1'b0}}, vld_q};

endmodule

// File: tb/tb_io_out_port_fifo.sv
// Directed bench for io_out_port_fifo: vector table plus
// hand sequences for backpressure and asynchronous reset.
module tb_io_out_port_fifo;

  typedef struct {
    logic        we;
    logic [15:0] din;
    logic        clr;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  ec;
    logic        ef;
    logic        eo;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [15:0] OutData = '0;
  logic        OutWe = 1'b0;
  logic        OvfClr = 1'b0;
  logic        DevReady = 1'b0;
  logic        Full;
  logic        Overflow;
  logic [15:0] DevData;
  logic        DevValid;
  logic [2:0]  Count;

  int tests = 0;
  int fails = 0;

  vec_t        vt[$];
  logic [15:0] exp_q[$];

  always #5 Clk = ~Clk;

  io_out_port_fifo dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .OutData  (OutData),
    .OutWe    (OutWe),
    .Full     (Full),
    .Overflow (Overflow),
    .OvfClr   (OvfClr),
    .DevData  (DevData),
    .DevValid (DevValid),
    .DevReady (DevReady),
    .Count    (Count)
  );

  function automatic vec_t mk(
    input logic we, input logic [15:0] din,
    input logic clr, input logic rdy,
    input logic ev, input logic [15:0] ed,
    input logic [2:0] ec, input logic ef,
    input logic eo);
    vec_t v;
    v.we = we; v.din = din; v.clr = clr;
    v.rdy = rdy; v.ev = ev; v.ed = ed;
    v.ec = ec; v.ef = ef; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string nm,
    input logic ev, input logic [15:0] ed,
    input logic [2:0] ec, input logic ef,
    input logic eo);
    tests++;
    if (DevValid !== ev || DevData !== ed ||
        Count !== ec || Full !== ef ||
        Overflow !== eo) begin
      fails++;
      $display("FAIL %s: got v=%b d=%h c=%0d f=%b o=%b want v=%b d=%h c=%0d f=%b o=%b",
        nm, DevValid, DevData, Count, Full, Overflow,
        ev, ed, ec, ef, eo);
    end
  endtask

  initial begin
    // T2 bypass
    vt.push_back(mk(1, 16'h0019, 0, 1, 1, 16'h0019, 1, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h0019, 0, 0, 0));
    // T3 fill with device stalled
    vt.push_back(mk(1, 16'h0005, 0, 0, 1, 16'h0005, 1, 0, 0));
    vt.push_back(mk(1, 16'hFFFF, 0, 0, 1, 16'h0005, 2, 0, 0));
    vt.push_back(mk(1, 16'hF320, 0, 0, 1, 16'h0005, 3, 0, 0));
    vt.push_back(mk(1, 16'h1111, 0, 0, 1, 16'h0005, 4, 0, 0));
    vt.push_back(mk(1, 16'h2222, 0, 0, 1, 16'h0005, 5, 1, 0));
    vt.push_back(mk(1, 16'h3333, 0, 0, 1, 16'h0005, 5, 1, 1));
    // T4 drain in order
    vt.push_back(mk(0, 16'h0000, 0, 1, 1, 16'hFFFF, 4, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 1, 16'hF320, 3, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h1111, 2, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 1, 16'h2222, 1, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0, 16'h2222, 0, 0, 1));
    // T6 clear alone, refill, clear+overflow same edge
    vt.push_back(mk(0, 16'h0000, 1, 1, 0, 16'h2222, 0, 0, 0));
    vt.push_back(mk(1, 16'hA001, 0, 0, 1, 16'hA001, 1, 0, 0));
    vt.push_back(mk(1, 16'hA002, 0, 0, 1, 16'hA001, 2, 0, 0));
    vt.push_back(mk(1, 16'hA003, 0, 0, 1, 16'hA001, 3, 0, 0));
    vt.push_back(mk(1, 16'hA004, 0, 0, 1, 16'hA001, 4, 0, 0));
    vt.push_back(mk(1, 16'hA005, 0, 0, 1, 16'hA001, 5, 1, 0));
    vt.push_back(mk(1, 16'hA006, 1, 0, 1, 16'hA001, 5, 1, 1));
    vt.push_back(mk(0, 16'h0000, 1, 0, 1, 16'hA001, 5, 1, 0));
    // write while full with a drain: still dropped
    vt.push_back(mk(1, 16'hA007, 0, 1, 1, 16'hA002, 4, 0, 1));
    // simultaneous storage read+write, count unchanged
    vt.push_back(mk(1, 16'hA008, 1, 1, 1, 16'hA003, 4, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 1, 1, 16'hA004, 3, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 1, 1, 16'hA005, 2, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 1, 1, 16'hA008, 1, 0, 0));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0, 16'hA008, 0, 0, 0));

    // reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("reset", 0, 16'h0000, 0, 0, 0);
    Rst = 1'b1;

    foreach (vt[i]) begin
      @(negedge Clk);
      OutWe    = vt[i].we;
      OutData  = vt[i].din;
      OvfClr   = vt[i].clr;
      DevReady = vt[i].rdy;
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d", i), vt[i].ev, vt[i].ed,
          vt[i].ec, vt[i].ef, vt[i].eo);
    end

    // T5 backpressure: ready toggles, core stalls on Full
    begin
      int sent = 0;
      int got = 0;
      logic hold;
      logic [15:0] held;
      @(negedge Clk);
      OvfClr = 1'b0;
      for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
        if (cyc > 0) @(negedge Clk);
        DevReady = (cyc % 2 == 0);
        if (sent < 12 && !Full) begin
          OutWe   = 1'b1;
          OutData = 16'hB000 + 16'(sent);
          exp_q.push_back(OutData);
          sent++;
        end else begin
          OutWe = 1'b0;
        end
        hold = DevValid & !DevReady;
        held = DevData;
        if (DevValid && DevReady) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL t5_order: got %h want none", DevData);
          end else begin
            if (DevData !== exp_q[0]) begin
              fails++;
              $display("FAIL t5_order: got %h want %h",
                       DevData, exp_q[0]);
            end
            void'(exp_q.pop_front());
          end
          got++;
        end
        @(posedge Clk);
        #1;
        if (hold) begin
          tests++;
          if (DevValid !== 1'b1 || DevData !== held) begin
            fails++;
            $display("FAIL t5_stable: got v=%b d=%h want v=1 d=%h",
                     DevValid, DevData, held);
          end
        end
      end
      tests++;
      if (got != 12) begin
        fails++;
        $display("FAIL t5_count: got %0d want 12", got);
      end
    end

    // T1 reset mid-traffic
    @(negedge Clk);
    OutWe = 1'b0;
    DevReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      OutWe   = 1'b1;
      OutData = 16'hD000 + 16'(i);
    end
    @(posedge Clk);
    #1;
    chk("t1_pre", 1, 16'hD000, 5, 1, 1);
    #2;
    Rst = 1'b0;
    #1;
    chk("t1_async", 0, 16'h0000, 0, 0, 0);
    @(posedge Clk);
    #1;
    chk("t1_hold", 0, 16'h0000, 0, 0, 0);
    @(negedge Clk);
    Rst      = 1'b1;
    OutWe    = 1'b1;
    OutData  = 16'hC0DE;
    DevReady = 1'b1;
    @(posedge Clk);
    #1;
    chk("t1_after", 1, 16'hC0DE, 1, 0, 0);
    @(negedge Clk);
    OutWe = 1'b0;
    @(posedge Clk);
    #1;
    chk("t1_empty", 0, 16'hC0DE, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
